linebuf_ctrl: RTL and testbench

Counter and flow-control block for the L2/L3 line buffer. It owns the write-side and read-side line/character pointers into the packet BRAM and stores the length of every committed line. It generates the start permissions (greenflags) and end-of-line flag consumed by the write-buffer and read-buffer state machines. It sits between those two FSMs and the BRAM address ports, and arbitrates buffer occupancy so that one writer and one reader share the line ring safely.

---
 rtl/linebuf_ctrl_pkg.sv | 13 +
 rtl/linebuf_len_rf.sv | 22 ++
 rtl/linebuf_ctrl.sv | 111 +++++++++++
 tb/tb_linebuf_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/linebuf_ctrl_pkg.sv
// Shared sizing constants for the line buffer controller and the write/read FSMs.
package linebuf_ctrl_pkg;

  localparam int LINE_W_DEF = 3;
  localparam int CHAR_W_DEF = 8;
  localparam int DROP_W_DEF = 16;
  localparam int ADDR_W_DEF = LINE_W_DEF + CHAR_W_DEF;

  function automatic int addr_width(input int line_w, input int char_w);
    return line_w + char_w;
  endfunction

endpackage

// File: rtl/linebuf_len_rf.sv
// Per-line length store: one synchronous write port, one asynchronous read port.
module linebuf_len_rf #(
  parameter int LINE_W = 3,
  parameter int CHAR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LINE_W-1:0] waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [LINE_W-1:0] raddr,
  output logic [CHAR_W-1:0] rdata
);

  logic [CHAR_W-1:0] mem [2**LINE_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/linebuf_ctrl.sv
// Pointer, occupancy and drop/error bookkeeping for the shared line ring in packet BRAM.
module linebuf_ctrl
  import linebuf_ctrl_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                wr_char_incr,
  input  logic                                wr_newline,
  input  logic                                wr_restart_line,
  input  logic                                rd_char_incr,
  input  logic                                rd_newline,
  output logic                                wr_greenflag,
  output logic                                rd_greenflag,
  output logic                                rd_lastflag,
  output logic [addr_width(LINE_W,CHAR_W)-1:0] wr_addr,
  output logic [addr_width(LINE_W,CHAR_W)-1:0] rd_addr,
  output logic [LINE_W:0]                     line_count,
  output logic [DROP_W-1:0]                   drop_cnt,
  output logic                                err
);

  localparam logic [LINE_W:0] FULL = {1'b1, {LINE_W{1'b0}}};

  logic [LINE_W-1:0] wr_line, rd_line;
  logic [CHAR_W-1:0] wr_char, rd_char, rd_len;
  logic [LINE_W:0]   count;
  logic              ovf;
  logic              full, empty;
  logic              commit, release_line, wr_drop, wr_err, rd_err;

  assign full  = (count == FULL);
  assign empty = (count == '0);

  // Restart wins over newline; an overflowed line is discarded before the full check applies.
  assign commit       = wr_newline & ~wr_restart_line & ~ovf & ~full;
  assign wr_drop      = wr_restart_line | (wr_newline & (ovf | full));
  assign wr_err       = wr_newline & ~wr_restart_line & ~ovf & full;
  assign release_line = rd_newline & ~empty;
  assign rd_err       = rd_newline & empty;

  linebuf_len_rf #(
    .LINE_W(LINE_W),
    .CHAR_W(CHAR_W)
  ) u_len_rf (
    .clk  (clk),
    .we   (commit & rst & ~flush),
    .waddr(wr_line),
    .wdata(wr_char),
    .raddr(rd_line),
    .rdata(rd_len)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_line  <= '0;
      wr_char  <= '0;
      rd_line  <= '0;
      rd_char  <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
      err      <= 1'b0;
    end else if (flush) begin
      wr_line <= '0;
      wr_char <= '0;
      rd_line <= '0;
      rd_char <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      if (wr_restart_line || wr_newline) begin
        wr_char <= '0;
        ovf     <= 1'b0;
      end else if (wr_char_incr) begin
        if (wr_char == '1) ovf <= 1'b1;
        else               wr_char <= wr_char + 1'b1;
      end

      if (commit) wr_line <= wr_line + 1'b1;

      if (release_line) begin
        rd_line <= rd_line + 1'b1;
        rd_char <= '0;
      end else if (rd_char_incr) begin
        rd_char <= rd_char + 1'b1;
      end

      case ({commit, release_line})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (wr_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (wr_err || rd_err) err <= 1'b1;
    end
  end

  assign wr_greenflag = ~full;
  assign rd_greenflag = ~empty;
  assign rd_lastflag  = (rd_char == rd_len);
  assign wr_addr      = {wr_line, wr_char};
  assign rd_addr      = {rd_line, rd_char};
  assign line_count   = count;

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Directed self-checking bench for linebuf_ctrl at the default 8-line x 256-char geometry.
module tb_linebuf_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        wr_char_incr = 1'b0;
  logic        wr_newline = 1'b0;
  logic        wr_restart_line = 1'b0;
  logic        rd_char_incr = 1'b0;
  logic        rd_newline = 1'b0;
  logic        wr_greenflag, rd_greenflag, rd_lastflag, err;
  logic [10:0] wr_addr, rd_addr;
  logic [3:0]  line_count;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail = 0;

  linebuf_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_char_incr(wr_char_incr), .wr_newline(wr_newline), .wr_restart_line(wr_restart_line),
    .rd_char_incr(rd_char_incr), .rd_newline(rd_newline),
    .wr_greenflag(wr_greenflag), .rd_greenflag(rd_greenflag), .rd_lastflag(rd_lastflag),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .line_count(line_count),
    .drop_cnt(drop_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Called at a falling edge: holds the inputs across one rising edge, returns at the next falling edge.
  task automatic drive(input logic wci, input logic wnl, input logic wrs,
                       input logic rci, input logic rnl, input logic fl);
    wr_char_incr = wci; wr_newline = wnl; wr_restart_line = wrs;
    rd_char_incr = rci; rd_newline = rnl; flush = fl;
    @(negedge clk);
    wr_char_incr = 1'b0; wr_newline = 1'b0; wr_restart_line = 1'b0;
    rd_char_incr = 1'b0; rd_newline = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_checks++; if (wr_greenflag !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_wr_greenflag: got %b expected 1", wr_greenflag); end
    n_checks++; if (rd_greenflag !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_greenflag: got %b expected 0", rd_greenflag); end
    n_checks++; if (wr_addr !== 11'h000) begin n_fail++; $display("[TB] FAIL reset_wr_addr: got %h expected 000", wr_addr); end
    n_checks++; if (rd_addr !== 11'h000) begin n_fail++; $display("[TB] FAIL reset_rd_addr: got %h expected 000", rd_addr); end
    n_checks++; if (line_count !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_line_count: got %0d expected 0", line_count); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_write_line;
    repeat (3) drive(1, 0, 0, 0, 0, 0);
    n_checks++; if (wr_addr !== 11'h003) begin n_fail++; $display("[TB] FAIL write_chars_addr: got %h expected 003", wr_addr); end
    drive(0, 1, 0, 0, 0, 0);
    n_checks++; if (line_count !== 4'd1) begin n_fail++; $display("[TB] FAIL write_line_count: got %0d expected 1", line_count); end
    n_checks++; if (rd_greenflag !== 1'b1) begin n_fail++; $display("[TB] FAIL write_rd_greenflag: got %b expected 1", rd_greenflag); end
    n_checks++; if (wr_addr !== 11'h100) begin n_fail++; $display("[TB] FAIL write_commit_addr: got %h expected 100", wr_addr); end
  endtask

  task automatic test_read_line;
    n_checks++; if (rd_lastflag !== 1'b0) begin n_fail++; $display("[TB] FAIL read_lastflag_c0: got %b expected 0", rd_lastflag); end
    repeat (2) drive(0, 0, 0, 1, 0, 0);
    n_checks++; if (rd_lastflag !== 1'b0) begin n_fail++; $display("[TB] FAIL read_lastflag_c2: got %b expected 0", rd_lastflag); end
    drive(0, 0, 0, 1, 0, 0);
    n_checks++; if (rd_addr !== 11'h003) begin n_fail++; $display("[TB] FAIL read_addr_c3: got %h expected 003", rd_addr); end
    n_checks++; if (rd_lastflag !== 1'b1) begin n_fail++; $display("[TB] FAIL read_lastflag_c3: got %b expected 1", rd_lastflag); end
    drive(0, 0, 0, 0, 1, 0);
    n_checks++; if (line_count !== 4'd0) begin n_fail++; $display("[TB] FAIL read_release_count: got %0d expected 0", line_count); end
    n_checks++; if (rd_addr !== 11'h100) begin n_fail++; $display("[TB] FAIL read_release_addr: got %h expected 100", rd_addr); end
    n_checks++; if (rd_greenflag !== 1'b0) begin n_fail++; $display("[TB] FAIL read_release_greenflag: got %b expected 0", rd_greenflag); end
  endtask

  // Pointers start at wr_line=1, rd_line=1, count=0.
  task automatic test_full;
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 0, 0);
    n_checks++; if (wr_greenflag !== 1'b0) begin n_fail++; $display("[TB] FAIL full_wr_greenflag: got %b expected 0", wr_greenflag); end
    n_checks++; if (line_count !== 4'd8) begin n_fail++; $display("[TB] FAIL full_line_count: got %0d expected 8", line_count); end
    n_checks++; if (wr_addr !== 11'h100) begin n_fail++; $display("[TB] FAIL full_wr_wrap_addr: got %h expected 100", wr_addr); end
    drive(0, 1, 0, 0, 0, 0);
    n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL full_drop_cnt: got %0d expected 1", drop_cnt); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL full_err: got %b expected 1", err); end
    n_checks++; if (line_count !== 4'd8) begin n_fail++; $display("[TB] FAIL full_count_hold: got %0d expected 8", line_count); end
    n_checks++; if (wr_addr !== 11'h100) begin n_fail++; $display("[TB] FAIL full_wr_addr_hold: got %h expected 100", wr_addr); end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);
    n_checks++; if (line_count !== 4'd4) begin n_fail++; $display("[TB] FAIL drain_count: got %0d expected 4", line_count); end
    n_checks++; if (rd_addr !== 11'h500) begin n_fail++; $display("[TB] FAIL drain_rd_addr: got %h expected 500", rd_addr); end
    n_checks++; if (rd_lastflag !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_empty_line_lastflag: got %b expected 1", rd_lastflag); end
  endtask

  // wr_line=1, rd_line=5, count=4 on entry.
  task automatic test_back_to_back;
    drive(0, 1, 0, 0, 1, 0);
    n_checks++; if (line_count !== 4'd4) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 4", line_count); end
    n_checks++; if (wr_addr !== 11'h200) begin n_fail++; $display("[TB] FAIL b2b_wr_addr: got %h expected 200", wr_addr); end
    n_checks++; if (rd_addr !== 11'h600) begin n_fail++; $display("[TB] FAIL b2b_rd_addr: got %h expected 600", rd_addr); end
    repeat (2) drive(0, 1, 0, 0, 1, 0);
    n_checks++; if (rd_addr !== 11'h000) begin n_fail++; $display("[TB] FAIL b2b_rd_wrap: got %h expected 000", rd_addr); end
    n_checks++; if (wr_addr !== 11'h400) begin n_fail++; $display("[TB] FAIL b2b_wr_addr2: got %h expected 400", wr_addr); end
    n_checks++; if (line_count !== 4'd4) begin n_fail++; $display("[TB] FAIL b2b_count2: got %0d expected 4", line_count); end
  endtask

  // wr_line=4, count=4, drop_cnt=1 on entry.
  task automatic test_overflow;
    repeat (255) drive(1, 0, 0, 0, 0, 0);
    n_checks++; if (wr_addr !== 11'h4FF) begin n_fail++; $display("[TB] FAIL ovf_last_char: got %h expected 4ff", wr_addr); end
    drive(1, 0, 0, 0, 0, 0);
    n_checks++; if (wr_addr !== 11'h4FF) begin n_fail++; $display("[TB] FAIL ovf_char_hold: got %h expected 4ff", wr_addr); end
    drive(0, 1, 0, 0, 0, 0);
    n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
    n_checks++; if (wr_addr !== 11'h400) begin n_fail++; $display("[TB] FAIL ovf_wr_addr: got %h expected 400", wr_addr); end
    n_checks++; if (line_count !== 4'd4) begin n_fail++; $display("[TB] FAIL ovf_count: got %0d expected 4", line_count); end
    repeat (5) drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    n_checks++; if (drop_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL restart_drop_cnt: got %0d expected 3", drop_cnt); end
    n_checks++; if (wr_addr !== 11'h400) begin n_fail++; $display("[TB] FAIL restart_wr_addr: got %h expected 400", wr_addr); end
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    n_checks++; if (line_count !== 4'd5) begin n_fail++; $display("[TB] FAIL post_ovf_commit_count: got %0d expected 5", line_count); end
    n_checks++; if (wr_addr !== 11'h500) begin n_fail++; $display("[TB] FAIL post_ovf_commit_addr: got %h expected 500", wr_addr); end
  endtask

  task automatic test_flush;
    repeat (17) drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    n_checks++; if (wr_addr !== 11'h511) begin n_fail++; $display("[TB] FAIL flush_pre_wr_addr: got %h expected 511", wr_addr); end
    drive(1, 1, 0, 1, 1, 1);
    n_checks++; if (wr_addr !== 11'h000) begin n_fail++; $display("[TB] FAIL flush_wr_addr: got %h expected 000", wr_addr); end
    n_checks++; if (rd_addr !== 11'h000) begin n_fail++; $display("[TB] FAIL flush_rd_addr: got %h expected 000", rd_addr); end
    n_checks++; if (line_count !== 4'd0) begin n_fail++; $display("[TB] FAIL flush_count: got %0d expected 0", line_count); end
    n_checks++; if (drop_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL flush_drop_kept: got %0d expected 3", drop_cnt); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_err_kept: got %b expected 1", err); end
    n_checks++; if (rd_greenflag !== 1'b0 || wr_greenflag !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_flags: got rd=%b wr=%b expected rd=0 wr=1", rd_greenflag, wr_greenflag); end
  endtask

  task automatic test_reset_midline;
    repeat (2) drive(0, 1, 0, 0, 0, 0);
    repeat (17) drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    n_checks++; if (wr_addr !== 11'h211 || line_count !== 4'd2) begin n_fail++; $display("[TB] FAIL midline_pre: got addr=%h count=%0d expected 211/2", wr_addr, line_count); end
    rst = 1'b0;
    drive(1, 0, 0, 1, 0, 0);
    rst = 1'b1;
    n_checks++; if (wr_addr !== 11'h000 || rd_addr !== 11'h000) begin n_fail++; $display("[TB] FAIL midline_rst_addr: got wr=%h rd=%h expected 000/000", wr_addr, rd_addr); end
    n_checks++; if (line_count !== 4'd0 || drop_cnt !== 16'd0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL midline_rst_state: got count=%0d drop=%0d err=%b expected 0/0/0", line_count, drop_cnt, err); end
    n_checks++; if (wr_greenflag !== 1'b1 || rd_greenflag !== 1'b0) begin n_fail++; $display("[TB] FAIL midline_rst_flags: got wr=%b rd=%b expected 1/0", wr_greenflag, rd_greenflag); end
    drive(0, 0, 0, 0, 1, 0);
    n_checks++; if (err !== 1'b1 || line_count !== 4'd0 || rd_addr !== 11'h000) begin n_fail++; $display("[TB] FAIL empty_release: got err=%b count=%0d rd=%h expected 1/0/000", err, line_count, rd_addr); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_line();
    test_read_line();
    test_full();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
